// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around mem_port_arbiter.
// slave = the arbiter itself; master = the requesters and memory around it.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Handshake: a requester raises *_req with stable addr/data and holds it
  // until *_gnt or *_done; *_gnt and *_done are single-cycle pulses, *_err
  // qualifies *_done, and *_rdata holds its value until the next read done.
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_done;
  logic          if_err;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_done;
  logic          d_err;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_done, if_err, if_rdata,
    output d_gnt, d_done, d_err, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_done, if_err, if_rdata,
    input  d_gnt, d_done, d_err, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the
// instruction-fetch path and the load/store path, with misalignment errors.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          owner_q;
  logic          win_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          mem_en_q, mem_we_q, busy_q;
  logic          if_gnt_q, if_done_q, if_err_q;
  logic          d_gnt_q, d_done_q, d_err_q;
  logic [DW-1:0] if_rdata_q, d_rdata_q;

  logic          any_req;
  logic          pick;
  logic [AW-1:0] sel_addr;

  // On a tie the requester that was not served last wins (0=fetch, 1=data).
  always_comb begin
    any_req  = bus.if_req | bus.d_req;
    pick     = 1'b0;
    if (bus.if_req && bus.d_req) pick = ~owner_q;
    else if (bus.d_req)          pick = 1'b1;
    sel_addr = pick ? bus.d_addr : bus.if_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      owner_q    <= 1'b1;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      if_gnt_q   <= 1'b0;
      if_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      d_done_q   <= 1'b0;
      d_err_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_gnt_q  <= 1'b0;
      if_done_q <= 1'b0;
      if_err_q  <= 1'b0;
      d_gnt_q   <= 1'b0;
      d_done_q  <= 1'b0;
      d_err_q   <= 1'b0;
      mem_we_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_q  <= pick;
            win_q    <= pick;
            busy_q   <= 1'b1;
            if_gnt_q <= ~pick;
            d_gnt_q  <= pick;
            if (sel_addr[1:0] != 2'b00) begin
              state     <= ERR;
              if_done_q <= ~pick;
              if_err_q  <= ~pick;
              d_done_q  <= pick;
              d_err_q   <= pick;
            end else begin
              state    <= BUSY;
              cnt      <= '0;
              addr_q   <= sel_addr;
              wdata_q  <= bus.d_wdata;
              we_q     <= pick & bus.d_we;
              mem_en_q <= 1'b1;
              // Write strobe only in the first BUSY cycle: one write per store.
              mem_we_q <= pick & bus.d_we;
            end
          end
        end
        BUSY: begin
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            mem_en_q  <= 1'b0;
            if_done_q <= ~win_q;
            d_done_q  <= win_q;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          if (!we_q) begin
            if (win_q) d_rdata_q  <= bus.mem_rdata;
            else       if_rdata_q <= bus.mem_rdata;
          end
        end
        ERR: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.d_done    = d_done_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a cycle table on a MEM_LAT=1 instance and
// hand-written store / reset / round-robin sequences on a MEM_LAT=3 instance.
module tb_mem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset1 = 1'b1;
  logic reset3 = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] st1, st3;
  mem_port_arbiter_if #(.AW(32), .DW(32)) b1 ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) b3 ();

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset1), .bus(b1.slave), .state_dbg(st1));
  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset3), .bus(b3.slave), .state_dbg(st3));

  // ---------------- memory models ----------------
  logic [31:0] mem1 [0:255];
  logic [31:0] rd1;
  always @(posedge clk) begin
    if (reset1) begin
      mem1[4]  <= 32'h00A00093;
      mem1[16] <= 32'h12345678;
    end else if (b1.mem_en && b1.mem_we) begin
      mem1[b1.mem_addr[9:2]] <= b1.mem_wdata;
    end
    rd1 <= b1.mem_en ? mem1[b1.mem_addr[9:2]] : 32'h0;
  end
  assign b1.mem_rdata = rd1;

  logic [31:0] mem3 [0:255];
  logic [31:0] p3 [0:2];
  int wr3_cnt = 0;
  always @(posedge clk) begin
    if (b3.mem_en && b3.mem_we) begin
      mem3[b3.mem_addr[9:2]] <= b3.mem_wdata;
      wr3_cnt <= wr3_cnt + 1;
    end
    p3[0] <= b3.mem_en ? mem3[b3.mem_addr[9:2]] : 32'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b3.mem_rdata = p3[2];

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // flags = {if_gnt,if_done,if_err,d_gnt,d_done,d_err,mem_en,mem_we,busy,owner}
  localparam logic [9:0] IG = 10'b1000000000, ID = 10'b0100000000, IE = 10'b0010000000;
  localparam logic [9:0] DG = 10'b0001000000, DD = 10'b0000100000, DE = 10'b0000010000;
  localparam logic [9:0] EN = 10'b0000001000, WE = 10'b0000000100, BZ = 10'b0000000010;
  localparam logic [9:0] OW = 10'b0000000001, NO = 10'b0000000000;
  localparam logic [31:0] A = 32'h00A00093, B = 32'h11112222, C = 32'h12345678;

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [9:0]  flags;
    logic [31:0] ird;
    logic [31:0] drd;
  } vec_t;

  vec_t vt [0:24];

  function automatic vec_t mk(input logic rst, input logic ireq, input logic [31:0] iaddr,
                              input logic dreq, input logic dwe, input logic [31:0] daddr,
                              input logic [31:0] dwdata, input logic [9:0] fl,
                              input logic [31:0] ird, input logic [31:0] drd);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
    v.daddr = daddr; v.dwdata = dwdata; v.flags = fl; v.ird = ird; v.drd = drd;
    return v;
  endfunction

  function automatic logic [9:0] flags_of1();
    return {b1.if_gnt, b1.if_done, b1.if_err, b1.d_gnt, b1.d_done, b1.d_err,
            b1.mem_en, b1.mem_we, b1.busy, b1.owner};
  endfunction

  function automatic logic [9:0] flags_of3();
    return {b3.if_gnt, b3.if_done, b3.if_err, b3.d_gnt, b3.d_done, b3.d_err,
            b3.mem_en, b3.mem_we, b3.busy, b3.owner};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive1(input vec_t v);
    reset1     = v.rst;
    b1.if_req  = v.ireq;
    b1.if_addr = v.iaddr;
    b1.d_req   = v.dreq;
    b1.d_we    = v.dwe;
    b1.d_addr  = v.daddr;
    b1.d_wdata = v.dwdata;
  endtask

  task automatic drive3(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                        input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata);
    b3.if_req  = ireq;
    b3.if_addr = iaddr;
    b3.d_req   = dreq;
    b3.d_we    = dwe;
    b3.d_addr  = daddr;
    b3.d_wdata = dwdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int en_n, we_n, gnt_at, done_at, wr_before, overlap, own_bad;
    logic [31:0] we_addr;

    drive1(mk(1'b1, 0, 0, 0, 0, 0, 0, NO, 0, 0));
    drive3(0, 0, 0, 0, 0, 0);

    vt[0]  = mk(1, 0, 32'h00, 0, 0, 32'h00, 32'h0,        OW,               0, 0);
    vt[1]  = mk(0, 0, 32'h00, 0, 0, 32'h00, 32'h0,        OW,               0, 0);
    vt[2]  = mk(0, 1, 32'h10, 0, 0, 32'h00, 32'h0,        IG|EN|BZ,         0, 0);
    vt[3]  = mk(0, 0, 32'h10, 0, 0, 32'h00, 32'h0,        ID|BZ,            0, 0);
    vt[4]  = mk(0, 0, 32'h10, 0, 0, 32'h00, 32'h0,        NO,               A, 0);
    vt[5]  = mk(0, 0, 32'h10, 0, 0, 32'h00, 32'h0,        NO,               A, 0);
    vt[6]  = mk(0, 0, 32'h00, 1, 1, 32'h44, B,            DG|EN|WE|BZ|OW,   A, 0);
    vt[7]  = mk(0, 0, 32'h00, 0, 1, 32'h44, B,            DD|BZ|OW,         A, 0);
    vt[8]  = mk(0, 0, 32'h00, 0, 0, 32'h00, 32'h0,        OW,               A, 0);
    vt[9]  = mk(0, 0, 32'h00, 1, 0, 32'h44, 32'h0,        DG|EN|BZ|OW,      A, 0);
    vt[10] = mk(0, 0, 32'h00, 0, 0, 32'h44, 32'h0,        DD|BZ|OW,         A, 0);
    vt[11] = mk(0, 0, 32'h00, 0, 0, 32'h00, 32'h0,        OW,               A, B);
    vt[12] = mk(0, 0, 32'h00, 1, 0, 32'h42, 32'h0,        DG|DD|DE|BZ|OW,   A, B);
    vt[13] = mk(0, 0, 32'h00, 0, 0, 32'h00, 32'h0,        OW,               A, B);
    vt[14] = mk(0, 1, 32'h11, 0, 0, 32'h00, 32'h0,        IG|ID|IE|BZ,      A, B);
    vt[15] = mk(0, 0, 32'h00, 0, 0, 32'h00, 32'h0,        NO,               A, B);
    vt[16] = mk(0, 1, 32'h44, 1, 0, 32'h40, 32'h0,        DG|EN|BZ|OW,      A, B);
    vt[17] = mk(0, 1, 32'h44, 1, 0, 32'h40, 32'h0,        DD|BZ|OW,         A, B);
    vt[18] = mk(0, 1, 32'h44, 1, 0, 32'h40, 32'h0,        OW,               A, C);
    vt[19] = mk(0, 1, 32'h44, 1, 0, 32'h40, 32'h0,        IG|EN|BZ,         A, C);
    vt[20] = mk(0, 1, 32'h44, 1, 0, 32'h40, 32'h0,        ID|BZ,            A, C);
    vt[21] = mk(0, 1, 32'h44, 1, 0, 32'h40, 32'h0,        NO,               B, C);
    vt[22] = mk(0, 1, 32'h44, 1, 0, 32'h40, 32'h0,        DG|EN|BZ|OW,      B, C);
    vt[23] = mk(0, 0, 32'h00, 0, 0, 32'h00, 32'h0,        DD|BZ|OW,         B, C);
    vt[24] = mk(0, 0, 32'h00, 0, 0, 32'h00, 32'h0,        OW,               B, C);

    // Table: inputs applied on the falling edge, outputs checked 1 after the rising edge.
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive1(vt[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d flags", i), 64'(flags_of1()), 64'(vt[i].flags));
      check($sformatf("v%0d if_rdata", i), 64'(b1.if_rdata), 64'(vt[i].ird));
      check($sformatf("v%0d d_rdata", i), 64'(b1.d_rdata), 64'(vt[i].drd));
    end

    // Store with MEM_LAT=3.
    @(negedge clk);
    reset3 = 1'b0;
    check("lat3 reset flags", 64'(flags_of3()), 64'(OW));
    @(negedge clk);
    drive3(0, 0, 1, 1, 32'h40, 32'hDEADBEEF);
    en_n = 0; we_n = 0; gnt_at = -1; done_at = -1; we_addr = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (b3.mem_en) en_n++;
      if (b3.mem_we) begin we_n++; we_addr = b3.mem_addr; end
      if (b3.d_gnt && gnt_at < 0) gnt_at = i;
      if (b3.d_done && done_at < 0) done_at = i;
      if (b3.d_gnt) b3.d_req = 1'b0;
    end
    check("store gnt cycle", 64'(gnt_at), 64'(1));
    check("store mem_en cycles", 64'(en_n), 64'(3));
    check("store mem_we cycles", 64'(we_n), 64'(1));
    check("store mem_addr", 64'(we_addr), 64'h40);
    check("store done cycle", 64'(done_at), 64'(4));
    check("store d_rdata", 64'(b3.d_rdata), 64'h0);
    check("store mem word", 64'(mem3[16]), 64'hDEADBEEF);
    check("store busy end", 64'(b3.busy), 64'(0));

    // Reset in the second BUSY cycle of a store.
    @(negedge clk);
    wr_before = wr3_cnt;
    drive3(0, 0, 1, 1, 32'h48, 32'h55AA55AA);
    @(posedge clk);
    #1;
    check("rst-store gnt", 64'(b3.d_gnt), 64'(1));
    b3.d_req = 1'b0;
    @(posedge clk);
    #1;
    check("rst-store busy", 64'(b3.busy), 64'(1));
    reset3 = 1'b1;
    #1;
    check("rst flags", 64'(flags_of3()), 64'(OW));
    check("rst mem_addr", 64'(b3.mem_addr), 64'h0);
    check("rst mem_wdata", 64'(b3.mem_wdata), 64'h0);
    check("rst state", 64'(st3), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst no d_done", 64'(b3.d_done), 64'(0));
    @(negedge clk);
    reset3 = 1'b0;

    // Both requesters held from reset: fetch, data, fetch, data.
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
    got_q.delete();
    overlap = 0; own_bad = 0;
    drive3(1, 32'h10, 1, 0, 32'h40, 32'h0);
    for (int i = 0; i < 40 && got_q.size() < 4; i++) begin
      @(posedge clk);
      #1;
      if (b3.if_gnt && b3.d_gnt) overlap++;
      if (b3.if_done && b3.d_done) overlap++;
      if (b3.if_gnt) begin got_q.push_back(32'd0); if (b3.owner !== 1'b0) own_bad++; end
      if (b3.d_gnt)  begin got_q.push_back(32'd1); if (b3.owner !== 1'b1) own_bad++; end
    end
    drive3(0, 0, 0, 0, 0, 0);
    check("rr grant count", 64'(got_q.size()), 64'(4));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("rr grant %0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    check("rr overlap", 64'(overlap), 64'(0));
    check("rr owner", 64'(own_bad), 64'(0));
    check("rst single write", 64'(wr3_cnt - wr_before), 64'(1));

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported instruction/data memory between two requesters: the instruction-fetch path (IR load) and the load/store data path (MDR/store).
- Arbitrates between them, sequences the fixed-latency memory access, and returns read data through a req/gnt/done handshake.
- Flags misaligned word addresses as an error response to the control unit, which raises the exception.
- Sits between the control FSM/datapath and the memory instance.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, memory read latency in cycles (>=1); mem_rdata is valid MEM_LAT cycles after the first cycle mem_en is high

Ports:
- clk  in  1  clock
- reset  in  1  reset
- if_req  in  1  fetch request; held high until if_gnt or if_done
- if_addr  in  AW  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_done  out  1  one-cycle pulse: fetch finished
- if_err  out  1  valid with if_done: misaligned address
- if_rdata  out  DW  fetched word; holds until the next fetch if_done
- d_req  in  1  data request; held high until d_gnt or d_done
- d_we  in  1  1=store, 0=load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_done  out  1  one-cycle pulse: data access finished
- d_err  out  1  valid with d_done: misaligned address
- d_rdata  out  DW  loaded word; holds until the next load d_done
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high whenever state is not IDLE
- owner  out  1  current or last grant: 0=fetch, 1=data

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values:
  - state=IDLE.
  - All pulses, mem_en, mem_we and busy = 0.
  - mem_addr, mem_wdata, if_rdata and d_rdata = 0.
  - owner=1, so fetch wins the first tie.
- Reset asserted mid-access abandons the access: no done is issued and no further write occurs.
- States: IDLE, BUSY, DONE, ERR.
- IDLE: sampled on the clock edge.
  - Only one request high: that requester wins.
  - Both high: the requester not equal to owner wins (round-robin).
  - Winner with addr[1:0]!=0 -> ERR.
  - Otherwise -> BUSY. Latch addr, wdata and we (we is forced to 0 for fetch), set owner=winner, clear the latency counter.
- BUSY: lasts exactly MEM_LAT cycles.
  - mem_en=1 throughout; mem_addr and mem_wdata come from the latched registers.
  - mem_we=1 only in the first BUSY cycle, so each store writes once.
  - Winner's gnt pulses in the first BUSY cycle.
  - When the counter reaches MEM_LAT-1 -> DONE. Counter width is clog2(MEM_LAT+1) and it saturates, never wraps.
- DONE: one cycle.
  - mem_en=0.
  - Winner's done=1 and err=0.
  - For a read, capture mem_rdata into the winner's rdata register on this edge; the value is visible from the next cycle and held thereafter.
  - Store done leaves d_rdata unchanged.
  - -> IDLE.
- ERR: one cycle.
  - Winner's gnt=1, done=1 and err=1; no memory access (mem_en=0) and rdata unchanged.
  - owner is updated.
  - -> IDLE.
- Latency: request sampled at edge k -> gnt in cycle k+1 -> done in cycle k+MEM_LAT+1 -> next arbitration at edge k+MEM_LAT+2.
- Requests arriving while busy are ignored until IDLE; a requester that keeps req high is served in round-robin order.
- Requester inputs change only after gnt; the block never re-samples them during BUSY.
- if_gnt/d_gnt and if_done/d_done are never high simultaneously.

Test Plan:
- Fetch only, MEM_LAT=1, if_addr=0x10, memory word 0x00A00093:
  - if_gnt high 1 cycle after the sample.
  - mem_en high 1 cycle.
  - if_done high 2 cycles after the sample.
  - if_rdata=0x00A00093 and held; mem_we never 1.
- Store, d_addr=0x40, d_wdata=0xDEADBEEF, MEM_LAT=3:
  - mem_we high exactly 1 cycle with mem_addr=0x40.
  - mem_en high 3 cycles.
  - d_done 4 cycles after the sample; d_rdata unchanged.
- if_req and d_req both held high from reset:
  - Grant order fetch, data, fetch, data.
  - owner toggles each access.
  - No overlap of gnt or done pulses.
- Load with d_addr=0x42:
  - d_gnt, d_done and d_err all high in the same single cycle.
  - mem_en stays 0; back to IDLE next cycle.
- Reset pulsed during BUSY of a store with MEM_LAT=3:
  - All outputs 0 immediately.
  - No d_done.
  - owner=1; the next tie is won by fetch.
